// File: rtl/shadow_ctrl.sv
// Shadow block-cipher round controller: sequences an external byte-wide branch unit and key schedule.
// Optional abort input is enabled by defining SHADOW_CTRL_ABORT_EN.
module shadow_ctrl #(
   parameter int unsigned ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
`ifdef SHADOW_CTRL_ABORT_EN
   input  logic        abort,
`endif
   input  logic        start,
   input  logic [31:0] pt_in,
   input  logic [63:0] key_in,
   output logic        ready,
   output logic        done,
   output logic [31:0] ct_out,
   output logic [7:0]  br_in0,
   output logic [7:0]  br_in1,
   output logic [7:0]  br_key,
   input  logic [7:0]  br_out0,
   input  logic [7:0]  br_out1,
   output logic        ks_step,
   input  logic [63:0] ks_next
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [5:0] LAST_STEP  = 6'(4 * ROUNDS - 1);
   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] s_q, s_d;
   logic [63:0] k_q, k_d;
   logic [5:0]  step_q, step_d;
   logic [31:0] ct_out_q, ct_out_d;

   logic        abort_act;
   logic [1:0]  q;
   logic        in_run;
   logic        last_round;
   logic [15:0] half_sel;
   logic [15:0] half_wb;

`ifdef SHADOW_CTRL_ABORT_EN
   assign abort_act = abort;
`else
   assign abort_act = 1'b0;
`endif

   assign q          = step_q[1:0];
   assign in_run     = (state_q == ST_RUN);
   assign last_round = (step_q[5:2] == LAST_ROUND);

   // Even quarters work on the upper half of s, odd quarters on the lower half.
   // Operand selection is kept apart from the write-back so the external
   // combinational branch unit never closes a loop through one block.
   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      half_sel = q[0] ? s_q[15:0] : s_q[31:16];
      br_in0   = '0;
      br_in1   = '0;
      br_key   = '0;
      ks_step  = 1'b0;
      if (in_run) begin
         br_in0 = half_sel[15:8];
         br_in1 = half_sel[7:0];
         unique case (q)
            2'd0: br_key = k_q[63:56];
            2'd1: br_key = k_q[55:48];
            2'd2: br_key = k_q[47:40];
            default: br_key = k_q[39:32];
         endcase
         ks_step = (q == 2'd3) && !abort_act;
      end
   end

   // Second half of every round but the last writes the results back uncrossed.
   assign half_wb = (q[1] && !last_round) ? {br_out0, br_out1} : {br_out1, br_out0};

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      k_d      = k_q;
      step_d   = step_q;
      ct_out_d = ct_out_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort_act) begin
               state_d = ST_IDLE;
            end else begin
               s_d     = pt_in;
               k_d     = key_in;
               step_d  = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort_act) begin
               state_d = ST_IDLE;
            end else begin
               if (q[0]) s_d[15:0]  = half_wb;
               else      s_d[31:16] = half_wb;
               if (ks_step) k_d = ks_next;
               step_d = step_q + 6'd1;
               if (step_q == LAST_STEP) begin
                  state_d  = ST_DONE;
                  ct_out_d = s_d;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q  <= ST_IDLE;
         s_q      <= '0;
         k_q      <= '0;
         step_q   <= '0;
         ct_out_q <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         k_q      <= k_d;
         step_q   <= step_d;
         ct_out_q <= ct_out_d;
      end
   end

   assign ready  = (state_q == ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign ct_out = ct_out_q;

endmodule

// File: tb/tb_shadow_ctrl.sv
// Self-checking bench for shadow_ctrl: two instances (ROUNDS=16 and ROUNDS=1) with
// behavioural branch-unit and key-schedule stubs, table vectors, corner sequences and random blocks.
module tb_shadow_ctrl;

   typedef struct {
      bit          use16;
      logic [31:0] pt;
      logic [63:0] key;
      logic [31:0] exp_ct;
   } vec_t;

   typedef struct {
      logic [31:0] ct;
      int          lat;
      int          nks;
      bit          ready_low;
      bit          br_idle0;
      bit          got_done;
      bit          pulse_ok;
      bit          hold_ok;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sel16 = 1'b1;
   logic        br_mode = 1'b0;
   logic        ks_mode = 1'b0;
   logic [31:0] pt_in = '0;
   logic [63:0] key_in = '0;
`ifdef SHADOW_CTRL_ABORT_EN
   logic        abort = 1'b0;
`endif

   logic        start16, ready16, done16, ks_step16;
   logic [31:0] ct16;
   logic [7:0]  bi0_16, bi1_16, bk_16, bo0_16, bo1_16;
   logic [63:0] ksn16;
   logic [63:0] kst16 = '0;

   logic        start1, ready1, done1, ks_step1;
   logic [31:0] ct1;
   logic [7:0]  bi0_1, bi1_1, bk_1, bo0_1, bo1_1;
   logic [63:0] ksn1;
   logic [63:0] kst1 = '0;

   logic        ready_s, done_s, ks_step_s;
   logic [31:0] ct_s;
   logic [23:0] br_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [63:0] ks_fn(input logic [63:0] k);
      return {k[55:0], k[63:56]} ^ 64'h9E37_79B9_7F4A_7C15;
   endfunction

   // External units: branch unit is combinational, key schedule tracks its own copy of k.
   assign bo0_16 = bi0_16 ^ bk_16;
   assign bo1_16 = br_mode ? bi1_16 + bk_16 : bi1_16;
   assign bo0_1  = bi0_1 ^ bk_1;
   assign bo1_1  = br_mode ? bi1_1 + bk_1 : bi1_1;
   assign ksn16  = ks_mode ? ks_fn(kst16) : kst16;
   assign ksn1   = ks_mode ? ks_fn(kst1) : kst1;

   always @(posedge clk) begin
      if (start16 && ready16) kst16 <= key_in;
      else if (ks_step16)     kst16 <= ksn16;
      if (start1 && ready1)   kst1  <= key_in;
      else if (ks_step1)      kst1  <= ksn1;
   end

   assign start16   = start & sel16;
   assign start1    = start & ~sel16;
   assign ready_s   = sel16 ? ready16 : ready1;
   assign done_s    = sel16 ? done16 : done1;
   assign ks_step_s = sel16 ? ks_step16 : ks_step1;
   assign ct_s      = sel16 ? ct16 : ct1;
   assign br_s      = sel16 ? {bi0_16, bi1_16, bk_16} : {bi0_1, bi1_1, bk_1};

   shadow_ctrl #(.ROUNDS(16)) dut16 (
      .clk(clk), .rst(rst),
`ifdef SHADOW_CTRL_ABORT_EN
      .abort(abort),
`endif
      .start(start16), .pt_in(pt_in), .key_in(key_in),
      .ready(ready16), .done(done16), .ct_out(ct16),
      .br_in0(bi0_16), .br_in1(bi1_16), .br_key(bk_16),
      .br_out0(bo0_16), .br_out1(bo1_16),
      .ks_step(ks_step16), .ks_next(ksn16)
   );

   shadow_ctrl #(.ROUNDS(1)) dut1 (
      .clk(clk), .rst(rst),
`ifdef SHADOW_CTRL_ABORT_EN
      .abort(abort),
`endif
      .start(start1), .pt_in(pt_in), .key_in(key_in),
      .ready(ready1), .done(done1), .ct_out(ct1),
      .br_in0(bi0_1), .br_in1(bi1_1), .br_key(bk_1),
      .br_out0(bo0_1), .br_out1(bo1_1),
      .ks_step(ks_step1), .ks_next(ksn1)
   );

   // Reference cipher on a byte array: round r, quarter q mixes byte pair q%2 with key byte q.
   function automatic logic [31:0] model_ct(input logic [31:0] pt, input logic [63:0] key,
                                            input int rounds, input bit brm, input bit ksm);
      logic [7:0]  b [4];
      logic [63:0] k;
      logic [7:0]  kb, o0, o1;
      int          lo;
      for (int i = 0; i < 4; i++) b[i] = pt[31 - 8*i -: 8];
      k = key;
      for (int r = 0; r < rounds; r++) begin
         for (int qq = 0; qq < 4; qq++) begin
            lo = (qq % 2) * 2;
            kb = k[63 - 8*qq -: 8];
            o0 = b[lo] ^ kb;
            o1 = brm ? b[lo+1] + kb : b[lo+1];
            if (qq >= 2 && r != rounds - 1) begin
               b[lo] = o0; b[lo+1] = o1;
            end else begin
               b[lo] = o1; b[lo+1] = o0;
            end
         end
         if (ksm) k = ks_fn(k);
      end
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Latency counts posedges with the start-accept edge as number 1; done is sampled
   // 1 time unit after each edge.
   task automatic run_block(input bit use16, input logic [31:0] pt, input logic [63:0] key,
                            input bit hold, output res_t r);
      logic [31:0] ct0;
      @(negedge clk);
      sel16 = use16; pt_in = pt; key_in = key; start = 1'b1;
      @(posedge clk);
      #1;
      start = hold;
      r.lat = 1; r.nks = 0; r.ready_low = 1'b1; r.br_idle0 = (br_s == '0);
      r.got_done = 1'b0; r.pulse_ok = 1'b0; r.hold_ok = 1'b1; r.ct = '0;
      ct0 = ct_s;
      while (r.lat < 300) begin
         if (ready_s) r.ready_low = 1'b0;
         if (ks_step_s) r.nks++;
         if (done_s) begin
            r.got_done = 1'b1;
            r.ct = ct_s;
            start = 1'b0;
            if (br_s != '0) r.br_idle0 = 1'b0;
            break;
         end
         if (ct_s !== ct0) r.hold_ok = 1'b0;
         @(posedge clk);
         #1;
         r.lat++;
      end
      start = 1'b0;
      if (r.got_done) begin
         @(posedge clk);
         #1;
         r.pulse_ok = !done_s && ready_s && (ct_s === r.ct);
      end
   endtask

   task automatic check_block(input string tag, input res_t r, input int rounds,
                              input logic [31:0] exp);
      check({tag, ".done_seen"}, r.got_done, 1);
      check({tag, ".latency"}, r.lat, 4*rounds + 2);
      check({tag, ".ks_pulses"}, r.nks, rounds);
      check({tag, ".ready_low"}, r.ready_low, 1);
      check({tag, ".br_idle_zero"}, r.br_idle0, 1);
      check({tag, ".ct_hold"}, r.hold_ok, 1);
      check({tag, ".ct_out"}, r.ct, exp);
      check({tag, ".done_pulse"}, r.pulse_ok, 1);
   endtask

   task automatic watch_quiet(input int n, output int dones, output int kss);
      dones = 0; kss = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done_s) dones++;
         if (ks_step_s) kss++;
      end
   endtask

   initial begin
      vec_t        vecs [6];
      res_t        r, r2;
      int          dones, kss;
      logic [31:0] prev_ct, exp;
      bit          u16;

      vecs[0] = '{1'b0, 32'h0000_0000, 64'h0102_0304_0506_0708, 32'h0103_0204};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 64'h0,                   32'hFFFF_FFFF};
      vecs[2] = '{1'b0, 32'h1122_3344, 64'h0,                   32'h1122_3344};
      vecs[3] = '{1'b0, 32'h1122_3344, 64'h0102_0304_0506_0708, 32'h1021_3140};
      vecs[4] = '{1'b1, 32'h1122_3344, 64'h0,                   32'h2211_4433};
      vecs[5] = '{1'b1, 32'hDEAD_BEEF, 64'h0,                   32'hADDE_EFBE};

      // Reset for two cycles, then check idle outputs of both instances.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst.ready16", ready16, 1);
      check("rst.done16", done16, 0);
      check("rst.ct16", ct16, 0);
      check("rst.br16", {bi0_16, bi1_16, bk_16}, 0);
      check("rst.ks16", ks_step16, 0);
      check("rst.ready1", ready1, 1);
      check("rst.done1", done1, 0);
      check("rst.ct1", ct1, 0);

      for (int i = 0; i < 6; i++) begin
         run_block(vecs[i].use16, vecs[i].pt, vecs[i].key, 1'b0, r);
         check_block($sformatf("vec%0d", i), r, vecs[i].use16 ? 16 : 1, vecs[i].exp_ct);
      end

      // start held high through RUN, then a second identical block.
      exp = model_ct(32'hCAFE_F00D, 64'h0011_2233_4455_6677, 16, 1'b0, 1'b0);
      run_block(1'b1, 32'hCAFE_F00D, 64'h0011_2233_4455_6677, 1'b1, r);
      check_block("hold1", r, 16, exp);
      run_block(1'b1, 32'hCAFE_F00D, 64'h0011_2233_4455_6677, 1'b0, r2);
      check_block("hold2", r2, 16, exp);

      // rst has priority over start in the same cycle.
      @(negedge clk);
      sel16 = 1'b1; start = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_prio.ready", ready16, 1);
      check("rst_prio.ct", ct16, 0);
      start = 1'b0; rst = 1'b0;

      // Block with nonzero result, then rst at RUN step 20 of the next block.
      run_block(1'b1, 32'h1357_9BDF, 64'h8899_AABB_CCDD_EEFF, 1'b0, r);
      check("pre_rst.ct", r.ct, model_ct(32'h1357_9BDF, 64'h8899_AABB_CCDD_EEFF, 16, 1'b0, 1'b0));
      @(negedge clk);
      pt_in = 32'h2468_ACE0; key_in = 64'hA1B2_C3D4_E5F6_0718; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      check("step20.br_key", bk_16, 8'hA1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst.ready", ready16, 1);
      check("mid_rst.done", done16, 0);
      check("mid_rst.ct", ct16, 0);
      check("mid_rst.br", {bi0_16, bi1_16, bk_16}, 0);
      watch_quiet(80, dones, kss);
      check("mid_rst.no_done", dones, 0);

`ifdef SHADOW_CTRL_ABORT_EN
      run_block(1'b1, 32'h0F1E_2D3C, 64'h0123_4567_89AB_CDEF, 1'b0, r);
      prev_ct = r.ct;
      check("pre_abort.ct", prev_ct, model_ct(32'h0F1E_2D3C, 64'h0123_4567_89AB_CDEF, 16, 1'b0, 1'b0));
      @(negedge clk);
      pt_in = 32'h5555_AAAA; key_in = 64'hFEDC_BA98_7654_3210; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      kss = 0;
      for (int i = 0; i < 11; i++) begin
         if (ks_step16) kss++;
         @(posedge clk);
         #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort.ks_count", kss, 2);
      check("abort.ready", ready16, 1);
      check("abort.ct_keep", ct16, prev_ct);
      watch_quiet(80, dones, kss);
      check("abort.no_done", dones, 0);
      check("abort.no_ks", kss, 0);
`else
      prev_ct = '0;
`endif

      // Randomised blocks against the reference cipher with richer stubs.
      for (int i = 0; i < 20; i++) begin
         u16 = 1'($urandom_range(0, 1));
         @(negedge clk);
         br_mode = 1'($urandom_range(0, 1));
         ks_mode = 1'($urandom_range(0, 1));
         pt_in   = $urandom;
         key_in  = {$urandom, $urandom};
         exp = model_ct(pt_in, key_in, u16 ? 16 : 1, br_mode, ks_mode);
         run_block(u16, pt_in, key_in, 1'($urandom_range(0, 1)), r);
         check_block($sformatf("rnd%0d", i), r, u16 ? 16 : 1, exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shadow_ctrl.md
SHADOW_CTRL -- requirements
Module: shadow_ctrl

Interface
- REQ-001 SHALL have parameter ROUNDS, default 16, number of Shadow rounds per block (legal range 1..16).
- REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
- REQ-004 SHALL have port start, input, 1, request to encrypt pt_in under key_in.
- REQ-005 SHALL have port pt_in, input, 32, plaintext block.
- REQ-006 SHALL have port key_in, input, 64, initial round-key register value.
- REQ-007 SHALL have port ready, output, 1, high only in IDLE.
- REQ-008 SHALL have port done, output, 1, one-cycle pulse when ct_out becomes valid.
- REQ-009 SHALL have port ct_out, output, 32, ciphertext; holds its value until the next done.
- REQ-010 SHALL have port br_in0, output, 8; br_in1, output, 8; br_key, output, 8, operands to the external combinational branch unit.
- REQ-011 SHALL have port br_out0, input, 8; br_out1, input, 8, branch unit results for the same cycle.
- REQ-012 SHALL have port ks_step, output, 1; ks_next, input, 64, handshake to the external key-schedule block.

Function
- REQ-013 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
- REQ-014 IDLE SHALL move to LOAD only on start=1; start SHALL be ignored in all other states.
- REQ-015 LOAD SHALL last one cycle, capturing pt_in into 32-bit state s, key_in into 64-bit key register k, and clearing the 6-bit step counter.
- REQ-016 RUN SHALL last exactly 4*ROUNDS cycles (step 0..4*ROUNDS-1), one branch operation per cycle.
- REQ-017 Step quarter q=step[1:0] SHALL select: q0 in0=s[31:24], in1=s[23:16], key=k[63:56]; q1 s[15:8], s[7:0], k[55:48]; q2 s[31:24], s[23:16], k[47:40]; q3 s[15:8], s[7:0], k[39:32].
- REQ-018 Write-back in q0 and q1 SHALL be upper byte<=br_out1, lower byte<=br_out0 of the selected half.
- REQ-019 Write-back in q2 and q3 SHALL be upper<=br_out0, lower<=br_out1, except in the last round, where it SHALL follow the q0/q1 rule.
- REQ-020 ks_step SHALL pulse in every q3 cycle, and k SHALL load ks_next on that edge; the last round's pulse SHALL also occur.
- REQ-021 The final RUN cycle SHALL go to DONE. DONE SHALL drive done=1 with ct_out=s for one cycle and then return to IDLE.
- REQ-022 Latency SHALL be 4*ROUNDS+2 cycles from the start-accept edge to done (66 for ROUNDS=16).
- REQ-023 br_* outputs SHALL be 0 outside RUN.

Reset
- REQ-024 rst SHALL force IDLE, ready=1, done=0, ks_step=0, ct_out=0, s=0, k=0, step=0, and SHALL take priority over start in the same cycle.
- REQ-025 rst mid-RUN SHALL discard the block with no done pulse.

Configuration
- REQ-026 With macro SHADOW_CTRL_ABORT_EN defined, the module SHALL add input abort (1 bit). abort=1 in LOAD or RUN SHALL return to IDLE on the next edge with no done, with ct_out unchanged and no further ks_step. abort SHALL be ignored in IDLE and DONE.
- REQ-027 Without SHADOW_CTRL_ABORT_EN, the abort port SHALL not exist.

Verification (branch stub: br_out0=br_in0^br_key, br_out1=br_in1; key stub: ks_next=k)
- REQ-028 rst for 2 cycles -> ready=1, done=0, ct_out=0x00000000, br_*=0.
- REQ-029 ROUNDS=1, pt_in=0x00000000, key_in=0x0102030405060708, start -> done 6 cycles after accept, ct_out=0x01030204.
- REQ-030 ROUNDS=16, start -> done exactly 66 cycles later, 16 ks_step pulses, ready=0 throughout.
- REQ-031 start held high during RUN -> no restart; a second start after done -> a second block completes with an identical result.
- REQ-032 rst asserted at RUN step 20 -> IDLE next cycle, no done, ct_out=0.
- REQ-033 With SHADOW_CTRL_ABORT_EN, abort at step 10 -> ready=1 next cycle, ct_out keeps its previous value, and the ks_step count stops at 2.
